// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the multiply request/result handshake and the ALU operand/result
// wires between the multiply sequencer and its environment.
interface alu_mul_sequencer_if #(
   parameter int W = 8
);
   logic           Start;
   logic [W-1:0]   MulA;
   logic [W-1:0]   MulB;
   logic           Busy;
   logic           Done;
   logic [2*W-1:0] Product;
   logic [W-1:0]   AluA;
   logic [W-1:0]   AluB;
   logic [2:0]     AluOp;
   logic [W-1:0]   AluRslt;
   logic           AluSCo;

   // Requester / ALU side: issues requests, returns ALU results.
   modport master (
      output Start, MulA, MulB, AluRslt, AluSCo,
      input  Busy, Done, Product, AluA, AluB, AluOp
   );

   // Sequencer side.
   modport slave (
      input  Start, MulA, MulB, AluRslt, AluSCo,
      output Busy, Done, Product, AluA, AluB, AluOp
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned W x W -> 2W shift-and-add multiplier that borrows the shared ALU:
// one ADD per multiplier bit, carry-out folded back into the partial product.
module alu_mul_sequencer #(
   parameter int         W      = 8,
   parameter logic [2:0] OP_ADD = 3'b000
) (
   input  logic                Clk,
   input  logic                Reset,
   alu_mul_sequencer_if.slave  bus
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     hi_q,    hi_d;
   logic [W-1:0]     lo_q,    lo_d;
   logic [CW-1:0]    count_q, count_d;
   logic [2*W-1:0]   product_q, product_d;
   logic [2*W-1:0]   shifted;

   // Next-state, operand capture and partial-product update.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      count_d   = count_q;
      product_d = product_q;
      // {carry, sum, lo} shifted right by one, dropping the consumed lo[0].
      shifted   = {bus.AluSCo, bus.AluRslt, lo_q[W-1:1]};

      case (state_q)
         IDLE, DONE: begin
            if (bus.Start) begin
               mcand_d = bus.MulA;
               hi_d    = '0;
               lo_d    = bus.MulB;
               count_d = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            {hi_d, lo_d} = shifted;
            count_d      = count_q + 1'b1;
            if (count_q == CW'(W - 1)) begin
               state_d   = DONE;
               product_d = shifted;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; async reset abandons any partial multiply.
   always_ff @(posedge Clk or posedge Reset) begin
      // NOTE: every register is reset (no storage arrays here), so the block
      // comes out of reset fully defined, even mid-operation.
      if (Reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Status and ALU drive decoded from registers; ALU sees 0+0 outside RUN.
   always_comb begin
      bus.Busy    = (state_q == RUN);
      bus.Done    = (state_q == DONE);
      bus.Product = product_q;
      bus.AluOp   = OP_ADD;
      bus.AluA    = (state_q == RUN) ? hi_q : '0;
      bus.AluB    = (state_q == RUN && lo_q[0]) ? mcand_q : '0;
   end

endmodule
